// File: rtl/arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package arb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_D = 3'd1,
      BUSY_I = 3'd2,
      DONE   = 3'd3,
      STOP   = 3'd4
   } arb_state_t;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;
   localparam int ARB_BE_W   = 4;

endpackage

// File: rtl/mem_timeout.sv
// Busy-cycle watchdog: clears on clr, counts while en, flags the last allowed cycle.
// Latency: tc is combinational from the count and en.
// Backpressure: none; the counter holds when en is low.
module mem_timeout #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt;

   // tc marks the TIMEOUT-th cycle without completion, so the count never wraps.
   assign tc = en && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports, data first.
// Latency: grant 1 cycle after request, valid 1 cycle after mem_ready, 3 cycles minimum.
// Backpressure: requesters stall until their valid pulse; memory stalls via mem_ready.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W  = ARB_ADDR_W,
   parameter int DATA_W  = ARB_DATA_W,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   output logic                if_stall,
   input  logic                dm_read,
   input  logic                dm_write,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [DATA_W-1:0]   dm_wdata,
   input  logic [ARB_BE_W-1:0] dm_be,
   output logic [DATA_W-1:0]   dm_rdata,
   output logic                dm_valid,
   output logic                dm_stall,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [ARB_BE_W-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready,
   input  logic                halt,
   output logic                halted,
   output logic                mem_err
);

   arb_state_t state;
   logic       busy;
   logic       tmo_tc;

   assign busy     = (state == BUSY_D) || (state == BUSY_I);
   assign if_stall = if_req & ~if_valid;
   assign dm_stall = (dm_read | dm_write) & ~dm_valid;

   mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (state == IDLE),
      .en      (busy && !mem_ready),
      .tc      (tmo_tc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_valid  <= 1'b0;
         dm_valid  <= 1'b0;
         halted    <= 1'b0;
         mem_err   <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         dm_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (halt || mem_err) begin
                  state  <= STOP;
                  halted <= 1'b1;
               end else if (dm_read || dm_write) begin
                  state     <= BUSY_D;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_write;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  mem_be    <= dm_be;
               end else if (if_req) begin
                  state    <= BUSY_I;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= if_addr;
                  mem_be   <= '1;
               end
            end
            BUSY_D, BUSY_I: begin
               if (mem_ready) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
                  if (state == BUSY_D) begin
                     dm_valid <= 1'b1;
                     if (!mem_we) dm_rdata <= mem_rdata;
                  end else begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else if (tmo_tc) begin
                  // Hung memory: abandon the access without a completion pulse.
                  state   <= STOP;
                  mem_req <= 1'b0;
                  mem_err <= 1'b1;
                  halted  <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            STOP: state <= STOP;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector table plus corner-case sequences for mem_port_arbiter, with a completion scoreboard.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        if_stall;
   logic        dm_read;
   logic        dm_write;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        dm_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        halt;
   logic        halted;
   logic        mem_err;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .if_stall(if_stall),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata),
      .dm_valid(dm_valid), .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .halt(halt), .halted(halted), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fetch;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          dly;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_be;
   } vec_t;

   typedef struct {
      logic        fetch;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   vec_t        vt[6];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_if = 32'h0;
   logic [31:0] last_dm = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic fetch, input logic [31:0] rdata);
      exp_t e;
      e.fetch = fetch;
      e.rdata = rdata;
      sb.push_back(e);
   endtask

   // Called at the sample point of a DONE cycle: pops and checks one completion.
   task automatic chk_done();
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_empty: completion with no expectation, if_valid=%b dm_valid=%b", if_valid, dm_valid);
      end else begin
         e = sb.pop_front();
         if (e.fetch) begin
            chk("if_valid", {31'b0, if_valid}, 32'd1);
            chk("dm_valid_quiet", {31'b0, dm_valid}, 32'd0);
            chk("if_rdata", if_rdata, e.rdata);
            chk("if_stall_done", {31'b0, if_stall}, 32'd0);
            chk("dm_rdata_held", dm_rdata, last_dm);
            last_if = e.rdata;
         end else begin
            chk("dm_valid", {31'b0, dm_valid}, 32'd1);
            chk("if_valid_quiet", {31'b0, if_valid}, 32'd0);
            chk("dm_rdata", dm_rdata, e.rdata);
            chk("dm_stall_done", {31'b0, dm_stall}, 32'd0);
            chk("if_rdata_held", if_rdata, last_if);
            last_dm = e.rdata;
         end
      end
   endtask

   task automatic drop_reqs();
      if_req   = 1'b0;
      dm_read  = 1'b0;
      dm_write = 1'b0;
   endtask

   task automatic do_reset();
      step();
      reset_n = 1'b0;
      drop_reqs();
      halt      = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      last_if = 32'h0;
      last_dm = 32'h0;
   endtask

   task automatic run_txn(input vec_t v);
      int we_cnt;
      we_cnt = 0;
      step();
      if (v.fetch) begin
         if_req  = 1'b1;
         if_addr = v.addr;
      end else begin
         dm_read  = !v.wr;
         dm_write = v.wr;
         dm_addr  = v.addr;
         dm_wdata = v.wdata;
         dm_be    = v.be;
      end
      push(v.fetch, v.exp_rdata);
      @(negedge clk);
      chk("req_idle", {31'b0, mem_req}, 32'd0);
      for (int d = 0; d <= v.dly; d++) begin
         step();
         @(negedge clk);
         chk("busy_req", {31'b0, mem_req}, 32'd1);
         chk("busy_addr", mem_addr, v.addr);
         chk("busy_stall", {31'b0, (v.fetch ? if_stall : dm_stall)}, 32'd1);
         if (mem_we && mem_req) we_cnt++;
         if (d == 0) begin
            chk("busy_we", {31'b0, mem_we}, {31'b0, v.wr});
            chk("busy_be", {28'b0, mem_be}, {28'b0, v.exp_be});
            if (v.wr) chk("busy_wdata", mem_wdata, v.wdata);
         end
         mem_ready = (d == v.dly);
         mem_rdata = v.rdata;
      end
      step();
      mem_ready = 1'b0;
      @(negedge clk);
      chk("done_req", {31'b0, mem_req}, 32'd0);
      chk_done();
      if (v.wr) chk("store_we_cycles", we_cnt, v.dly + 1);
      step();
      drop_reqs();
      @(negedge clk);
      chk("pulse_once", {30'b0, if_valid, dm_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      vt[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        4'h0, 0, 32'h00500093, 32'h00500093, 4'hF};
      vt[1] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'hF, 1, 32'h11223344, 32'h11223344, 4'hF};
      vt[2] = '{1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 4, 32'h55555555, 32'h11223344, 4'hF};
      vt[3] = '{1'b1, 1'b0, 32'h44,  32'h0,        4'h0, 2, 32'h00A00113, 32'h00A00113, 4'hF};
      vt[4] = '{1'b0, 1'b1, 32'h204, 32'h01020304, 4'h3, 0, 32'h66666666, 32'h11223344, 4'h3};
      vt[5] = '{1'b0, 1'b0, 32'h208, 32'h0,        4'hC, 3, 32'hCAFEF00D, 32'hCAFEF00D, 4'hC};

      reset_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h0;
      dm_read = 1'b0; dm_write = 1'b1; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
      mem_rdata = 32'h0; mem_ready = 1'b1; halt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
      chk("rst_valids", {30'b0, if_valid, dm_valid}, 32'd0);
      chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
      chk("rst_flags", {30'b0, halted, mem_err}, 32'd0);
      chk("rst_stalls", {30'b0, if_stall, dm_stall}, 32'd3);
      drop_reqs();
      mem_ready = 1'b0;
      #1;
      chk("stall_follow", {30'b0, if_stall, dm_stall}, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) run_txn(vt[i]);

      // Simultaneous data and fetch requests: data is granted first.
      step();
      dm_read = 1'b1; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h44;
      push(1'b0, 32'hA5A5A5A5);
      push(1'b1, 32'h00000013);
      step();
      @(negedge clk);
      chk("both_addr", mem_addr, 32'h100);
      chk("both_we", {31'b0, mem_we}, 32'd0);
      mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
      step();
      mem_ready = 1'b0;
      @(negedge clk);
      chk_done();
      chk("both_if_stall_d", {31'b0, if_stall}, 32'd1);
      step();
      dm_read = 1'b0;
      @(negedge clk);
      chk("both_gap_req", {31'b0, mem_req}, 32'd0);
      chk("both_if_stall_i", {31'b0, if_stall}, 32'd1);
      step();
      @(negedge clk);
      chk("both_fetch_req", {31'b0, mem_req}, 32'd1);
      chk("both_fetch_addr", mem_addr, 32'h44);
      mem_ready = 1'b1; mem_rdata = 32'h00000013;
      step();
      mem_ready = 1'b0;
      @(negedge clk);
      chk_done();
      step();
      drop_reqs();

      // Reset during BUSY_D, held load re-issued afterwards.
      step();
      dm_read = 1'b1; dm_addr = 32'h300;
      step();
      @(negedge clk);
      chk("prerst_req", {31'b0, mem_req}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_req", {31'b0, mem_req}, 32'd0);
      chk("arst_addr", mem_addr, 32'h0);
      chk("arst_dm_rdata", dm_rdata, 32'h0);
      last_if = 32'h0;
      last_dm = 32'h0;
      @(negedge clk);
      chk("arst_no_valid", {30'b0, if_valid, dm_valid}, 32'd0);
      reset_n = 1'b1;
      push(1'b0, 32'h0BADF00D);
      step();
      @(negedge clk);
      chk("reissue_req", {31'b0, mem_req}, 32'd1);
      chk("reissue_addr", mem_addr, 32'h300);
      mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
      step();
      mem_ready = 1'b0;
      @(negedge clk);
      chk_done();
      step();
      drop_reqs();

      // Halt during a fetch: the fetch completes, then the arbiter stops.
      step();
      if_req = 1'b1; if_addr = 32'h48;
      push(1'b1, 32'h13579BDF);
      step();
      @(negedge clk);
      chk("halt_busy_req", {31'b0, mem_req}, 32'd1);
      halt = 1'b1;
      step();
      @(negedge clk);
      chk("halt_busy_hold", {31'b0, mem_req}, 32'd1);
      mem_ready = 1'b1; mem_rdata = 32'h13579BDF;
      step();
      mem_ready = 1'b0;
      @(negedge clk);
      chk_done();
      step();
      @(negedge clk);
      chk("halt_idle_req", {31'b0, mem_req}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         mem_ready = 1'b1;
         @(negedge clk);
         chk("stop_halted", {31'b0, halted}, 32'd1);
         chk("stop_req", {31'b0, mem_req}, 32'd0);
         chk("stop_if_stall", {31'b0, if_stall}, 32'd1);
         chk("stop_no_valid", {31'b0, if_valid}, 32'd0);
      end
      do_reset();
      chk("unhalt", {31'b0, halted}, 32'd0);

      // Memory never answers: timeout after 8 busy cycles.
      step();
      if_req = 1'b1; if_addr = 32'h80;
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         @(negedge clk);
         chk("tmo_no_valid", {31'b0, if_valid}, 32'd0);
         if (!mem_req) break;
         chk("tmo_err_early", {31'b0, mem_err}, 32'd0);
         cnt++;
      end
      chk("tmo_busy_cycles", cnt, 32'd8);
      chk("tmo_err", {31'b0, mem_err}, 32'd1);
      chk("tmo_halted", {31'b0, halted}, 32'd1);
      chk("tmo_req_low", {31'b0, mem_req}, 32'd0);
      chk("sb_drained", sb.size(), 32'd0);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
